ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV64M multiply/divide unit in the EX stage. It executes every M-extension op: MUL, MULH, MULHSU, MULHU, MULW, DIV, DIVU, REM, REMU and the W forms. It drives the `exe_stall_req` input of the hazard unit. That request holds PC, IF/ID and ID/EX and bubbles EX/MEM until the result is ready, then the instruction advances with its result.

## Interface

**Parameters**
- `XLEN`, default 64: operand and result width. Only 64 is supported.

**Ports**
- `clock` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `mdu_valid` input 1: the ID/EX register holds an M-extension op.
- `mdu_op` input 4: operation code.
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW.
  - 8 DIV, 9 DIVU, 10 REM, 11 REMU.
  - 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW.
  - 5–7 are reserved and treated as MUL.
- `src1` input XLEN: rs1 operand.
- `src2` input XLEN: rs2 operand.
- `flush` input 1: abort any operation in progress.
- `mdu_stall_req` output 1: goes to `exe_stall_req` of the hazard unit.
- `mdu_result_valid` output 1: `mdu_result` is valid this cycle.
- `mdu_result` output XLEN: result, muxed into the EX/MEM write-back data.

## Operation

**States:** IDLE, BUSY, DONE. Reset and `flush` both force IDLE. `flush` has priority over all other transitions.

**IDLE**
- `mdu_stall_req = mdu_valid`, combinational.
- When `mdu_valid` is high:
  - Latch the op and the operand magnitudes.
  - Latch the quotient sign (s1^s2 for signed divides) and the remainder/product sign.
  - Load iteration count N: 64 for full-width ops, 32 for W ops.
  - Next state is BUSY, except in the special cases below, which go directly to DONE.

**BUSY**
- `mdu_stall_req = 1`.
- One radix-2 step per cycle; the counter decrements each cycle.
- Multiply: shift-add of the unsigned magnitudes into a 128-bit accumulator.
- Divide: restoring algorithm, one quotient bit per cycle.
- When the counter reaches 1, the final step completes:
  - Sign correction is applied.
  - `mdu_result` is registered.
  - Next state is DONE.

**DONE**
- `mdu_stall_req = 0`.
- `mdu_result_valid = 1`.
- `mdu_valid` is ignored: the same instruction is still in EX and leaves at this edge.
- Next state is IDLE unconditionally.

**Operand handling**
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- W ops use `src[31:0]`, sign- or zero-extended per op. The 32-bit result is sign-extended to 64 bits; this includes DIVUW and REMUW.
- Result selection:
  - MUL, MULW: low half of the product.
  - MULH*: high 64 bits of the 128-bit signed-corrected product.
- Remainder takes the sign of the dividend.

**Special cases (IDLE → DONE, no BUSY)**
- Divisor == 0 (at the op width):
  - Quotient is all ones.
  - Remainder is the dividend (sign-extended for W ops).
- Signed overflow (most-negative ÷ −1 at the op width):
  - Quotient is the dividend.
  - Remainder is 0.

## Timing

- **Reset values:** `mdu_stall_req = 0` (state IDLE, provided `mdu_valid` is low), `mdu_result_valid = 0`, `mdu_result = 0`, counter 0.
- **Normal op** (cycle 0 is the first cycle `mdu_valid` is seen in IDLE):
  - Stall is high in cycles 0..N.
  - DONE is cycle N+1, with the result valid.
  - Total EX occupancy is N+2 cycles: 66 for 64-bit ops, 34 for W ops.
- **Special-case op:**
  - Stall is high in cycle 0 only.
  - Result is valid in cycle 1.
  - Occupancy is 2 cycles.
- **Back-to-back ops:** a new `mdu_valid` is accepted in the IDLE cycle immediately after DONE. There are no idle gaps beyond that.
- **Flush:**
  - `flush` in any state returns to IDLE at the next edge.
  - `mdu_result_valid` is never asserted for an aborted op.
  - `mdu_stall_req` is low in the flush cycle itself.
- **Mid-operation reset:** same behaviour as flush; all registers return to their reset values.
- **Result hold:** `mdu_result` holds its value until the next DONE or reset.

## Test plan

1. **MUL:** `src1 = 7`, `src2 = 0xFFFFFFFFFFFFFFFD` → result `0xFFFFFFFFFFFFFFEB`. Stall high for exactly 65 cycles; `mdu_result_valid` pulses one cycle at cycle 65.
2. **MULHU and MULH:**
   - MULHU all-ones × all-ones → `0xFFFFFFFFFFFFFFFE`.
   - MULH all-ones × all-ones → `0`.
3. **Divide by zero:**
   - DIVU 5/0 → `0xFFFFFFFFFFFFFFFF`.
   - REM −5/0 → `0xFFFFFFFFFFFFFFFB`.
   - Each: stall high 1 cycle, result valid at cycle 1.
4. **Signed overflow:**
   - DIV `0x8000000000000000` / `0xFFFFFFFFFFFFFFFF` → `0x8000000000000000`.
   - REM of the same operands → `0`.
   - DIVW `0x80000000` / −1 → `0xFFFFFFFF80000000`.
5. **W ops:**
   - DIVW −7/2 → `0xFFFFFFFFFFFFFFFD`.
   - REMW −7/2 → `0xFFFFFFFFFFFFFFFF`.
   - DIVUW `0xFFFFFFFE`/1 → `0xFFFFFFFFFFFFFFFE`.
   - Each: stall high 33 cycles.
6. **Flush, then back-to-back:**
   - Assert `flush` at cycle 10 of a DIV → stall low in the flush cycle, state IDLE at the next cycle, no `mdu_result_valid`.
   - Then issue MUL 3×4 and DIVU 12/4 back-to-back → results `12` and `3` on consecutive DONE pulses, 66 cycles apart.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Handshake and operand/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(
   parameter int XLEN = 64
);
   logic            mdu_valid;
   logic [3:0]      mdu_op;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            flush;
   logic            mdu_stall_req;
   logic            mdu_result_valid;
   logic [XLEN-1:0] mdu_result;

   modport master (
      output mdu_valid, mdu_op, src1, src2, flush,
      input  mdu_stall_req, mdu_result_valid, mdu_result
   );

   modport slave (
      input  mdu_valid, mdu_op, src1, src2, flush,
      output mdu_stall_req, mdu_result_valid, mdu_result
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign correction folded into the final step.
module ex_muldiv #(
   parameter int XLEN = 64
) (
   input logic        clock,
   input logic        reset,
   ex_muldiv_if.slave mdu
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_r, state_next_s;
   logic [6:0]        cnt_r;
   logic [XLEN-1:0]   a_r, b_r, result_r;
   logic [2*XLEN-1:0] acc_r;
   logic              is_div_r, is_w_r, is_rem_r, neg_q_r, neg_r_r;
   logic [1:0]        mul_sel_r;

   logic              op_div_s, op_w_s, op_rem_s, sgn1_s, sgn2_s;
   logic [1:0]        mul_sel_s;
   logic [XLEN-1:0]   x1_s, x2_s, mag1_s, mag2_s, load_a_s, load_b_s, pre_b_s;
   logic [XLEN-1:0]   dividend_res_s, special_res_s;
   logic              neg1_s, neg2_s, zero_raw_s, ovf_raw_s, special_s;
   logic [2*XLEN-1:0] mul_acc_s, step_acc_s, prod_s;
   logic [XLEN:0]     rem_sh_s, rem_sub_s;
   logic              q_bit_s;
   logic [XLEN-1:0]   div_rem_s, step_b_s, quo_s, rem_s, div_sel_s, final_s;
   logic              stall_s;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Decode the incoming op into class, width, signedness and result selection
   always_comb begin
      op_div_s  = mdu.mdu_op[3];
      op_w_s    = 1'b0;
      op_rem_s  = 1'b0;
      sgn1_s    = 1'b0;
      sgn2_s    = 1'b0;
      mul_sel_s = 2'd0;
      if (op_div_s) begin
         op_w_s   = mdu.mdu_op[2];
         op_rem_s = mdu.mdu_op[1];
         sgn1_s   = ~mdu.mdu_op[0];
         sgn2_s   = ~mdu.mdu_op[0];
      end else begin
         // MUL/MULW only keep low product bits, so they run unsigned
         case (mdu.mdu_op[2:0])
            3'd1:    begin mul_sel_s = 2'd1; sgn1_s = 1'b1; sgn2_s = 1'b1; end
            3'd2:    begin mul_sel_s = 2'd1; sgn1_s = 1'b1; end
            3'd3:    mul_sel_s = 2'd1;
            3'd4:    begin mul_sel_s = 2'd2; op_w_s = 1'b1; end
            default: mul_sel_s = 2'd0;
         endcase
      end
   end

   // Operand extension, magnitudes and special-case detection at the op width
   always_comb begin
      if (op_w_s) begin
         x1_s           = sgn1_s ? sext32(mdu.src1[31:0]) : {32'd0, mdu.src1[31:0]};
         x2_s           = sgn2_s ? sext32(mdu.src2[31:0]) : {32'd0, mdu.src2[31:0]};
         zero_raw_s     = (mdu.src2[31:0] == 32'd0);
         ovf_raw_s      = (mdu.src1[31:0] == 32'h8000_0000) && (mdu.src2[31:0] == 32'hFFFF_FFFF);
         dividend_res_s = sext32(mdu.src1[31:0]);
      end else begin
         x1_s           = mdu.src1;
         x2_s           = mdu.src2;
         zero_raw_s     = (mdu.src2 == 64'd0);
         ovf_raw_s      = (mdu.src1 == 64'h8000_0000_0000_0000) && (mdu.src2 == 64'hFFFF_FFFF_FFFF_FFFF);
         dividend_res_s = mdu.src1;
      end
      neg1_s    = sgn1_s & x1_s[XLEN-1];
      neg2_s    = sgn2_s & x2_s[XLEN-1];
      mag1_s    = neg1_s ? (64'd0 - x1_s) : x1_s;
      mag2_s    = neg2_s ? (64'd0 - x2_s) : x2_s;
      special_s = op_div_s & (zero_raw_s | (sgn1_s & ovf_raw_s));
      if (zero_raw_s) begin
         special_res_s = op_rem_s ? dividend_res_s : 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
         special_res_s = op_rem_s ? 64'd0 : dividend_res_s;
      end
      // a holds multiplicand/divisor; b shifts out multiplier/dividend MSB-first
      load_a_s = op_div_s ? mag2_s : mag1_s;
      pre_b_s  = op_div_s ? mag1_s : mag2_s;
      load_b_s = op_w_s ? {pre_b_s[31:0], 32'd0} : pre_b_s;
   end

   // One radix-2 iteration plus sign correction and result selection
   always_comb begin
      mul_acc_s  = {acc_r[2*XLEN-2:0], 1'b0} + (b_r[XLEN-1] ? {64'd0, a_r} : 128'd0);
      rem_sh_s   = {acc_r[XLEN-1:0], b_r[XLEN-1]};
      rem_sub_s  = rem_sh_s - {1'b0, a_r};
      q_bit_s    = ~rem_sub_s[XLEN];
      div_rem_s  = q_bit_s ? rem_sub_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
      step_acc_s = is_div_r ? {64'd0, div_rem_s} : mul_acc_s;
      step_b_s   = {b_r[XLEN-2:0], (is_div_r & q_bit_s)};
      prod_s     = neg_r_r ? (128'd0 - step_acc_s) : step_acc_s;
      quo_s      = neg_q_r ? (64'd0 - step_b_s) : step_b_s;
      rem_s      = neg_r_r ? (64'd0 - div_rem_s) : div_rem_s;
      div_sel_s  = is_rem_r ? rem_s : quo_s;
      final_s    = 64'd0;
      if (is_div_r) begin
         final_s = is_w_r ? sext32(div_sel_s[31:0]) : div_sel_s;
      end else begin
         case (mul_sel_r)
            2'd1:    final_s = prod_s[2*XLEN-1:XLEN];
            2'd2:    final_s = sext32(prod_s[31:0]);
            default: final_s = prod_s[XLEN-1:0];
         endcase
      end
   end

   // Next-state and stall request; flush overrides everything
   always_comb begin
      state_next_s = state_r;
      stall_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            stall_s = mdu.mdu_valid;
            if (mdu.mdu_valid) begin
               state_next_s = special_s ? ST_DONE : ST_BUSY;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            stall_s = 1'b1;
            if (cnt_r == 7'd1) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_BUSY;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
      if (mdu.flush) begin
         state_next_s = ST_IDLE;
         stall_s      = 1'b0;
      end else begin
         state_next_s = state_next_s;
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand capture, iteration datapath and result register
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r     <= 7'd0;
         a_r       <= 64'd0;
         b_r       <= 64'd0;
         acc_r     <= 128'd0;
         result_r  <= 64'd0;
         is_div_r  <= 1'b0;
         is_w_r    <= 1'b0;
         is_rem_r  <= 1'b0;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         mul_sel_r <= 2'd0;
      end else if (mdu.flush) begin
         cnt_r <= 7'd0;
      end else if (state_r == ST_IDLE && mdu.mdu_valid) begin
         is_div_r  <= op_div_s;
         is_w_r    <= op_w_s;
         is_rem_r  <= op_rem_s;
         mul_sel_r <= mul_sel_s;
         neg_q_r   <= neg1_s ^ neg2_s;
         neg_r_r   <= op_div_s ? neg1_s : (neg1_s ^ neg2_s);
         a_r       <= load_a_s;
         b_r       <= load_b_s;
         acc_r     <= 128'd0;
         if (special_s) begin
            cnt_r    <= 7'd0;
            result_r <= special_res_s;
         end else begin
            cnt_r <= op_w_s ? 7'd32 : 7'd64;
         end
      end else if (state_r == ST_BUSY) begin
         acc_r <= step_acc_s;
         b_r   <= step_b_s;
         cnt_r <= cnt_r - 7'd1;
         if (cnt_r == 7'd1) begin
            result_r <= final_s;
         end
      end
   end

   assign mdu.mdu_stall_req    = stall_s;
   assign mdu.mdu_result_valid = (state_r == ST_DONE);
   assign mdu.mdu_result       = result_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases, flush, reset and random ops
// against an arithmetic reference model.
module tb_ex_muldiv;

   logic clock = 1'b0;
   logic reset;
   ex_muldiv_if #(.XLEN(64)) mif();
   ex_muldiv #(.XLEN(64)) dut (.clock(clock), .reset(reset), .mdu(mif));

   always #5 clock = ~clock;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc_abs = 0;
   int last_done = 0;

   always @(posedge clock) cyc_abs <= cyc_abs + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   // RISC-V M-extension semantics computed with plain arithmetic
   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
      logic signed [127:0] pa, pb, pp;
      logic [127:0]        up;
      logic signed [63:0]  sa, sb;
      logic signed [31:0]  wa, wb;
      logic [31:0]         ua, ub, wr;
      logic [63:0]         r;
      logic                z, zw, ov, ovw;
      sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      pa = sa; pb = sb;
      up = {64'd0, a} * {64'd0, b};
      z   = (b == 64'd0);
      zw  = (ub == 32'd0);
      ov  = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      ovw = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
      r = 64'd0; wr = 32'd0;
      case (op)
         4'd1: begin pp = pa * pb; r = pp[127:64]; end
         4'd2: begin pp = pa * $signed({64'd0, b}); r = pp[127:64]; end
         4'd3: r = up[127:64];
         4'd4: begin wr = ua * ub; r = {{32{wr[31]}}, wr}; end
         4'd8:  if (z) r = '1; else if (ov) r = a; else r = sa / sb;
         4'd9:  if (z) r = '1; else r = a / b;
         4'd10: if (z) r = a; else if (ov) r = 64'd0; else r = sa % sb;
         4'd11: if (z) r = a; else r = a % b;
         4'd12: if (zw) wr = '1; else if (ovw) wr = ua; else wr = wa / wb;
         4'd13: if (zw) wr = '1; else wr = ua / ub;
         4'd14: if (zw) wr = ua; else if (ovw) wr = 32'd0; else wr = wa % wb;
         4'd15: if (zw) wr = ua; else wr = ua % ub;
         default: r = a * b;
      endcase
      if (op >= 4'd12) r = {{32{wr[31]}}, wr};
      return r;
   endfunction

   // Stall cycles before the result: 1 for special divides, else N+1
   function automatic int ref_latency(input logic [3:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
      logic w, zero, ovf;
      w = (op == 4'd4) || (op >= 4'd12);
      if (op[3]) begin
         zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
         ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
         if (zero || ovf) return 1;
      end
      return w ? 33 : 65;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input string tag, output logic [63:0] res_o);
      logic [63:0] exp_v;
      int          exp_lat, stalls, cyc, vcyc;
      bit          got;
      exp_v   = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      mif.mdu_op = op; mif.src1 = a; mif.src2 = b; mif.mdu_valid = 1'b1;
      stalls = 0; cyc = 0; vcyc = -1; got = 1'b0; res_o = 64'd0;
      #1;
      while (!got && cyc < 100) begin
         if (mif.mdu_stall_req) stalls++;
         if (mif.mdu_result_valid) begin
            got = 1'b1; vcyc = cyc; res_o = mif.mdu_result; last_done = cyc_abs;
         end
         @(posedge clock); #1;
         cyc++;
      end
      chk({tag, "_done"}, 64'(got), 64'd1);
      chk({tag, "_res"}, res_o, exp_v);
      chk({tag, "_stall"}, 64'(stalls), 64'(exp_lat));
      chk({tag, "_vcyc"}, 64'(vcyc), 64'(exp_lat));
      chk({tag, "_pulse"}, 64'(mif.mdu_result_valid), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r1, r2, a, b;
      logic [3:0]  op;
      bit          seen;
      int          d1;
      reset = 1'b1;
      mif.mdu_valid = 1'b0; mif.mdu_op = 4'd0; mif.src1 = 64'd0; mif.src2 = 64'd0;
      mif.flush = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_stall", 64'(mif.mdu_stall_req), 64'd0);
      chk("rst_rv", 64'(mif.mdu_result_valid), 64'd0);
      chk("rst_res", mif.mdu_result, 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul", r1);
      chk("mul_const", r1, 64'hFFFF_FFFF_FFFF_FFEB);
      issue(4'd3, '1, '1, "mulhu", r1);
      chk("mulhu_const", r1, 64'hFFFF_FFFF_FFFF_FFFE);
      issue(4'd1, '1, '1, "mulh", r1);
      chk("mulh_const", r1, 64'd0);
      issue(4'd9, 64'd5, 64'd0, "divu0", r1);
      chk("divu0_const", r1, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(4'd10, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, "rem0", r1);
      chk("rem0_const", r1, 64'hFFFF_FFFF_FFFF_FFFB);
      issue(4'd8, 64'h8000_0000_0000_0000, '1, "divovf", r1);
      chk("divovf_const", r1, 64'h8000_0000_0000_0000);
      issue(4'd10, 64'h8000_0000_0000_0000, '1, "removf", r1);
      chk("removf_const", r1, 64'd0);
      issue(4'd12, 64'h0000_0000_8000_0000, '1, "divwovf", r1);
      chk("divwovf_const", r1, 64'hFFFF_FFFF_8000_0000);
      issue(4'd12, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "divw", r1);
      chk("divw_const", r1, 64'hFFFF_FFFF_FFFF_FFFD);
      issue(4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "remw", r1);
      chk("remw_const", r1, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(4'd13, 64'h0000_0000_FFFF_FFFE, 64'd1, "divuw", r1);
      chk("divuw_const", r1, 64'hFFFF_FFFF_FFFF_FFFE);

      mif.mdu_valid = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      chk("hold_res", mif.mdu_result, 64'hFFFF_FFFF_FFFF_FFFE);

      // Flush a DIV in its tenth cycle
      mif.mdu_op = 4'd8; mif.src1 = 64'd1000; mif.src2 = 64'd7; mif.mdu_valid = 1'b1;
      repeat (10) begin @(posedge clock); #1; end
      mif.flush = 1'b1;
      #1;
      chk("flush_stall", 64'(mif.mdu_stall_req), 64'd0);
      @(posedge clock); #1;
      mif.flush = 1'b0; mif.mdu_valid = 1'b0;
      #1;
      chk("flush_idle", 64'(mif.mdu_stall_req), 64'd0);
      chk("flush_hold", mif.mdu_result, 64'hFFFF_FFFF_FFFF_FFFE);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clock); #1;
         if (mif.mdu_result_valid) seen = 1'b1;
      end
      chk("flush_novalid", 64'(seen), 64'd0);

      issue(4'd0, 64'd3, 64'd4, "b2b_mul", r1);
      d1 = last_done;
      issue(4'd9, 64'd12, 64'd4, "b2b_divu", r2);
      chk("b2b_r1", r1, 64'd12);
      chk("b2b_r2", r2, 64'd3);
      chk("b2b_gap", 64'(last_done - d1), 64'd66);

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: b = 64'd0;
            1: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
            2: begin a = 64'h8000_0000_0000_0000; b = '1; end
            3: begin
               a = 64'($urandom_range(0, 1000));
               b = 64'($urandom_range(1, 50));
               if ($urandom_range(0, 1) == 1) a = 64'd0 - a;
               if ($urandom_range(0, 1) == 1) b = 64'd0 - b;
            end
            4: b = {$urandom | 32'd1, 32'd0};
            default: a = a;
         endcase
         issue(op, a, b, $sformatf("rnd%0d_op%0d", i, op), r1);
         mif.mdu_valid = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            repeat (2) @(posedge clock);
            #1;
         end
      end

      // Reset in the middle of a divide
      mif.mdu_op = 4'd9; mif.src1 = 64'd999; mif.src2 = 64'd10; mif.mdu_valid = 1'b1;
      repeat (5) begin @(posedge clock); #1; end
      reset = 1'b1; mif.mdu_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk("midrst_res", mif.mdu_result, 64'd0);
      chk("midrst_rv", 64'(mif.mdu_result_valid), 64'd0);
      chk("midrst_stall", 64'(mif.mdu_stall_req), 64'd0);
      issue(4'd11, 64'd999, 64'd10, "after_rst", r1);
      mif.mdu_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
